// File: rtl/scc_load_store_unit.sv
// scc_load_store_unit
//
// Load/store unit between the SCC datapath and the data port of the combined
// instruction/data memory. Takes one byte, halfword or word access at a time
// from the core and turns it into word-aligned big-endian accesses on a 32-bit
// memory port. Sub-word stores use read-modify-write. Load results are
// lane-selected and then sign- or zero-extended.
//
// Ports:
//   mem_Clk, mem_Rst_n   clock; asynchronous active-low reset
//   req, we, size        core request, store select, access size
//                        (00 byte, 01 half, 10 word, 11 illegal)
//   unsigned_ld          loads: 1 zero-extend, 0 sign-extend
//   addr, wdata          byte address, store data (low 8/16/32 bits used)
//   halt_f               blocks acceptance of new requests
//   busy, done, err      status; err is valid while done is high
//   rdata                load result, held until the next load completes
//   data_memory_*        word address, read/write strobes, write data,
//                        asynchronous read data
//
// Every output is driven straight from a flop.

module scc_load_store_unit (
  input  logic        mem_Clk,
  input  logic        mem_Rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        halt_f,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] data_memory_a,
  output logic        data_memory_read,
  output logic        data_memory_write,
  output logic [31:0] data_memory_out_v,
  input  logic [31:0] data_memory_in_v
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  state_e      state_q, state_d;

  // Request fields latched on accept.
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;

  // Output registers.
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] maddr_q, maddr_d;
  logic        mrd_q, mrd_d;
  logic        mwr_q, mwr_d;
  logic [31:0] mout_q, mout_d;

  logic        accept;
  logic        misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic [31:0] st_merge;

  assign accept = (state_q == StIdle) && req && !halt_f;

  assign misaligned = (size == 2'b11) ||
                      ((size == SzHalf) && addr[0]) ||
                      ((size == SzWord) && (addr[1:0] != 2'b00));

  // Big-endian lane select: lane 0 is the most significant byte.
  always_comb begin
    ld_byte = 8'h00;
    unique case (lane_q)
      2'd0: ld_byte = data_memory_in_v[31:24];
      2'd1: ld_byte = data_memory_in_v[23:16];
      2'd2: ld_byte = data_memory_in_v[15:8];
      2'd3: ld_byte = data_memory_in_v[7:0];
      default: ld_byte = 8'h00;
    endcase
    ld_half = lane_q[1] ? data_memory_in_v[15:0] : data_memory_in_v[31:16];
  end

  always_comb begin
    ld_value = data_memory_in_v;
    unique case (size_q)
      SzByte: ld_value = uns_q ? {24'h000000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SzHalf: ld_value = uns_q ? {16'h0000, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_value = data_memory_in_v;
    endcase
  end

  // Read-modify-write merge: replace only the addressed lane(s) of the word just read.
  always_comb begin
    st_merge = data_memory_in_v;
    unique case (size_q)
      SzByte: begin
        unique case (lane_q)
          2'd0: st_merge[31:24] = wdata_q[7:0];
          2'd1: st_merge[23:16] = wdata_q[7:0];
          2'd2: st_merge[15:8]  = wdata_q[7:0];
          2'd3: st_merge[7:0]   = wdata_q[7:0];
          default: st_merge = data_memory_in_v;
        endcase
      end
      SzHalf: begin
        if (lane_q[1]) begin
          st_merge[15:0] = wdata_q[15:0];
        end else begin
          st_merge[31:16] = wdata_q[15:0];
        end
      end
      default: st_merge = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    maddr_d = maddr_q;
    mrd_d   = 1'b0;
    mwr_d   = 1'b0;
    mout_d  = mout_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d    = we;
          size_d  = size;
          uns_d   = unsigned_ld;
          lane_d  = addr[1:0];
          wdata_d = wdata;
          maddr_d = {addr[31:2], 2'b00};
          busy_d  = 1'b1;
          if (misaligned) begin
            // Rejected accesses finish without ever touching memory.
            state_d = StDone;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (we && (size == SzWord)) begin
            state_d = StWr;
            mwr_d   = 1'b1;
            mout_d  = wdata;
          end else begin
            // Loads and sub-word stores both need the current word first.
            state_d = StRd;
            mrd_d   = 1'b1;
          end
        end
      end
      StRd: begin
        busy_d = 1'b1;
        if (we_q) begin
          state_d = StWr;
          mwr_d   = 1'b1;
          mout_d  = st_merge;
        end else begin
          state_d = StDone;
          done_d  = 1'b1;
          rdata_d = ld_value;
        end
      end
      StWr: begin
        state_d = StDone;
        busy_d  = 1'b1;
        done_d  = 1'b1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge mem_Clk or negedge mem_Rst_n) begin
    if (!mem_Rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      wdata_q <= 32'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      maddr_q <= 32'h0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      mout_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      maddr_q <= maddr_d;
      mrd_q   <= mrd_d;
      mwr_q   <= mwr_d;
      mout_q  <= mout_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign rdata             = rdata_q;
  assign data_memory_a     = maddr_q;
  assign data_memory_read  = mrd_q;
  assign data_memory_write = mwr_q;
  assign data_memory_out_v = mout_q;

endmodule
